uart_file_receiver: RTL

Parametrised UART file-transfer receiver between the rx/tx byte FIFOs of the UART core and user logic. Runs the SOH/EOT/SOT/EOF handshake with ACK/NAK replies, decodes a configurable-length hex header, buffers payload bytes in an internal FIFO of configurable depth, and reports byte count and completion. Optional checksum verification of the payload.

---
 rtl/uart_file_receiver_pkg.sv | 33 +++
 rtl/uart_rx_sync_fifo.sv | 46 ++++
 rtl/uart_file_receiver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_file_receiver_pkg.sv
// uart_file_receiver_pkg: shared control bytes, FSM encoding and hex-char decode.
package uart_file_receiver_pkg;

    localparam logic [7:0] C_SOH = 8'h01;
    localparam logic [7:0] C_SOT = 8'h02;
    localparam logic [7:0] C_EOT = 8'h03;
    localparam logic [7:0] C_EOF = 8'h04;
    localparam logic [7:0] C_ACK = 8'h06;
    localparam logic [7:0] C_NAK = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ACK_SOH  = 4'd1,
        S_RX_HDR   = 4'd2,
        S_WAIT_EOT = 4'd3,
        S_ACK_EOT  = 4'd4,
        S_WAIT_SOT = 4'd5,
        S_ACK_SOT  = 4'd6,
        S_RX_CONT  = 4'd7,
        S_RX_CSUM  = 4'd8,
        S_RESP_EOF = 4'd9,
        S_NAK_HDR  = 4'd10,
        S_DONE     = 4'd11
    } state_t;

    // ASCII hex char to nibble; bit 4 flags a non-hex character
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b0, c[3:0]} :
               ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) ? {1'b0, c[3:0] + 4'd9} :
               5'h10;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: 8-bit first-word-fall-through FIFO with count-based full/empty.
module uart_rx_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we_i,
    input  logic [7:0] din_i,
    input  logic       re_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign wr      = we_i & ~full_o;
    assign rd      = re_i & ~empty_o;
    assign dout_o  = mem_q[rp_q];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/uart_file_receiver.sv
// uart_file_receiver: SOH/EOT/SOT/EOF file handshake, hex header decode and payload buffering.
// Define UART_FILE_RX_CSUM_EN to verify a two-hex-char modulo-256 payload checksum after EOF.
module uart_file_receiver
    import uart_file_receiver_pkg::*;
#(
    parameter int HDR_BYTES  = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [3:0]             state,
    input  logic [7:0]             rx_data,
    input  logic                   rx_data_rdy,
    output logic                   rx_read_en,
    input  logic                   tx_fifo_full,
    output logic [7:0]             tx_din,
    output logic                   tx_write_en,
    output logic [7:0]             receive_fifo_dout,
    output logic                   receive_data_rdy,
    input  logic                   receive_fifo_re,
    output logic [8*HDR_BYTES-1:0] hdr_data,
    output logic                   hdr_valid,
    output logic                   hdr_error,
    output logic [CNT_W-1:0]       content_count,
    output logic                   file_done,
    output logic                   csum_ok
);

    localparam int HW = 8 * HDR_BYTES;
    localparam int NW = $clog2(2 * HDR_BYTES) + 1;
`ifdef UART_FILE_RX_CSUM_EN
    localparam state_t EOF_NEXT = S_RX_CSUM;
`else
    localparam state_t EOF_NEXT = S_RESP_EOF;
`endif

    state_t         state_q, state_d;
    logic [HW-1:0]  hdr_q, hdr_d;
    logic [NW-1:0]  nib_cnt_q, nib_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           hdr_valid_q, hdr_valid_d, hdr_error_q, hdr_error_d;
    logic [4:0]     nib;
    logic           hdr_last, hdr_pop, fifo_full, fifo_empty, fifo_we;
`ifdef UART_FILE_RX_CSUM_EN
    logic [7:0]     sum_q, sum_d;
    logic [3:0]     hi_q, hi_d;
    logic           csum_ok_q, csum_ok_d, csum_pop;
`endif

    assign nib      = hex2nib(rx_data);
    assign hdr_last = nib_cnt_q == NW'(2 * HDR_BYTES - 1);
    assign hdr_pop  = rx_read_en && state_q == S_RX_HDR;
    assign fifo_we  = rx_read_en && state_q == S_RX_CONT && rx_data != C_EOF && rx_data != C_SOT;

    assign state            = state_q;
    assign hdr_data         = hdr_q;
    assign hdr_valid        = hdr_valid_q;
    assign hdr_error        = hdr_error_q;
    assign content_count    = cnt_q;
    assign receive_data_rdy = ~fifo_empty;
`ifdef UART_FILE_RX_CSUM_EN
    assign csum_ok  = csum_ok_q;
    assign csum_pop = rx_read_en && state_q == S_RX_CSUM;
`else
    assign csum_ok  = 1'b1;
`endif

    uart_rx_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .we_i    (fifo_we),
        .din_i   (rx_data),
        .re_i    (receive_fifo_re),
        .dout_o  (receive_fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next state: pop-driven states advance on the consumed byte, reply states on the tx write
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rx_read_en && rx_data == C_SOH) state_d = S_ACK_SOH;
            S_ACK_SOH:  if (tx_write_en) state_d = S_RX_HDR;
            S_RX_HDR:   if (rx_read_en) state_d = nib[4] ? S_NAK_HDR : hdr_last ? S_WAIT_EOT : S_RX_HDR;
            S_WAIT_EOT: if (rx_read_en && rx_data == C_EOT) state_d = S_ACK_EOT;
            S_ACK_EOT:  if (tx_write_en) state_d = S_WAIT_SOT;
            S_WAIT_SOT: if (rx_read_en && rx_data == C_SOT) state_d = S_ACK_SOT;
            S_ACK_SOT:  if (tx_write_en) state_d = S_RX_CONT;
            S_RX_CONT:  if (rx_read_en && rx_data == C_EOF) state_d = EOF_NEXT;
`ifdef UART_FILE_RX_CSUM_EN
            S_RX_CSUM:  if (rx_read_en && (nib[4] || nib_cnt_q[0])) state_d = S_RESP_EOF;
`endif
            S_RESP_EOF: if (tx_write_en) state_d = S_DONE;
            S_NAK_HDR:  if (tx_write_en) state_d = S_IDLE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // outputs: rx pops gated by payload backpressure, tx replies gated by tx FIFO space
    always_comb begin
        rx_read_en  = ~reset & rx_data_rdy &
                      ((state_q inside {S_IDLE, S_RX_HDR, S_WAIT_EOT, S_WAIT_SOT, S_RX_CSUM}) ||
                       (state_q == S_RX_CONT && (rx_data == C_EOF || rx_data == C_SOT || !fifo_full)));
        tx_write_en = ~reset & ~tx_fifo_full &
                      (state_q inside {S_ACK_SOH, S_ACK_EOT, S_ACK_SOT, S_RESP_EOF, S_NAK_HDR});
        tx_din      = (state_q == S_NAK_HDR || (state_q == S_RESP_EOF && !csum_ok)) ? C_NAK : C_ACK;
        file_done   = state_q == S_DONE;
    end

    // header shift, nibble counting, payload count and status pulses
    always_comb begin
        nib_cnt_d   = (state_q == S_RX_HDR || state_q == S_RX_CSUM) ? nib_cnt_q + NW'(rx_read_en & ~nib[4]) : '0;
        hdr_d       = (hdr_pop && !nib[4]) ? {hdr_q[HW-5:0], nib[3:0]} : hdr_q;
        hdr_valid_d = hdr_pop && !nib[4] && hdr_last;
        hdr_error_d = hdr_pop && nib[4];
        cnt_d       = state_q == S_ACK_SOH ? '0 : (fifo_we && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef UART_FILE_RX_CSUM_EN
        sum_d       = state_q == S_ACK_SOH ? 8'h00 : fifo_we ? sum_q + rx_data : sum_q;
        hi_d        = (csum_pop && !nib_cnt_q[0]) ? nib[3:0] : hi_q;
        csum_ok_d   = !csum_pop ? csum_ok_q : nib[4] ? 1'b0 :
                      nib_cnt_q[0] ? ({hi_q, nib[3:0]} == sum_q) : csum_ok_q;
`endif
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q       <= '0;
            nib_cnt_q   <= '0;
            cnt_q       <= '0;
            hdr_valid_q <= 1'b0;
            hdr_error_q <= 1'b0;
`ifdef UART_FILE_RX_CSUM_EN
            sum_q       <= 8'h00;
            hi_q        <= 4'h0;
            csum_ok_q   <= 1'b1;
`endif
        end else begin
            hdr_q       <= hdr_d;
            nib_cnt_q   <= nib_cnt_d;
            cnt_q       <= cnt_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_error_q <= hdr_error_d;
`ifdef UART_FILE_RX_CSUM_EN
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            csum_ok_q   <= csum_ok_d;
`endif
        end
    end

endmodule
